// File: rtl/fusion_ctrl.sv
// fusion_ctrl: sequences a single job through a column of fusion-unit rows.
// It accepts a command, holds its width/sign configuration on the fu_*
// outputs, and issues operand beats into row 0. A tag pipe as deep as the
// column tracks each beat, and the last row's psum is added into a lane-wise
// accumulator when that beat's tag exits. The result is held until it is
// accepted.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   cmd_valid/cmd_ready         job handshake; cmd_* fields sampled on accept
//   cmd_in_width/weight_width   one-hot {8,4,2,1} operand widths
//   cmd_s_in/cmd_s_weight       operand signedness
//   cmd_len                     number of beats in the job
//   src_valid/src_ready         operand beat handshake
//   fu_en                       beat valid into row 0
//   fu_in_width..fu_s_weight    configuration held for the array
//   psum_out                    psum leaving the last row
//   res_valid/res_ready         result handshake
//   res_data, res_err           accumulated result, bad-width flag
//
// state  | meaning
// IDLE   | waiting for a command
// LOAD   | one cycle to validate the latched command
// ISSUE  | passing operand beats into row 0
// DRAIN  | waiting for in-flight beats to leave the last row
// DONE   | result presented until accepted

module fusion_ctrl #(
  parameter int COL_WIDTH = 13,
  parameter int ROWS      = 4,
  parameter int LEN_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_in_width,
  input  logic [3:0]             cmd_weight_width,
  input  logic                   cmd_s_in,
  input  logic                   cmd_s_weight,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic                   fu_en,
  output logic [3:0]             fu_in_width,
  output logic [3:0]             fu_weight_width,
  output logic                   fu_s_in,
  output logic                   fu_s_weight,
  input  logic [4*COL_WIDTH-1:0] psum_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*COL_WIDTH-1:0] res_data,
  output logic                   res_err
);

  localparam int C = COL_WIDTH;
  localparam int W = 4 * COL_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       in_width_q, in_width_d;
  logic [3:0]       weight_width_q, weight_width_d;
  logic             s_in_q, s_in_d;
  logic             s_weight_q, s_weight_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0]  tag_q, tag_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             err_q, err_d;
  logic [W-1:0]     acc_sum;
  logic             cfg_ok;
  logic             beat;

  assign cmd_ready       = (state_q == S_IDLE);
  assign src_ready       = (state_q == S_ISSUE);
  assign fu_en           = src_ready & src_valid;
  assign beat            = fu_en;
  assign res_valid       = (state_q == S_DONE);
  assign res_err         = res_valid & err_q;
  assign res_data        = res_valid ? acc_q : '0;
  assign fu_in_width     = in_width_q;
  assign fu_weight_width = weight_width_q;
  assign fu_s_in         = s_in_q;
  assign fu_s_weight     = s_weight_q;

  assign cfg_ok = $onehot(in_width_q) && $onehot(weight_width_q);

  // Lane split follows the weight width; lanes never carry into each other.
  // 2b and 1b weights share the four-lane layout.
  always_comb begin
    acc_sum = '0;
    if (weight_width_q[3]) begin
      acc_sum = acc_q + psum_out;
    end else if (weight_width_q[2]) begin
      acc_sum[2*C-1:0] = acc_q[2*C-1:0] + psum_out[2*C-1:0];
      acc_sum[W-1:2*C] = acc_q[W-1:2*C] + psum_out[W-1:2*C];
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc_sum[i*C +: C] = acc_q[i*C +: C] + psum_out[i*C +: C];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    in_width_d     = in_width_q;
    weight_width_d = weight_width_q;
    s_in_d         = s_in_q;
    s_weight_d     = s_weight_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    acc_d          = acc_q;
    // Tag for a beat issued this cycle exits ROWS cycles later, aligned
    // with that beat's psum at the last row.
    tag_d          = (tag_q << 1) | ROWS'(fu_en);

    if (tag_q[ROWS-1]) begin
      acc_d = acc_sum;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          in_width_d     = cmd_in_width;
          weight_width_d = cmd_weight_width;
          s_in_d         = cmd_s_in;
          s_weight_d     = cmd_s_weight;
          len_d          = cmd_len;
          cnt_d          = '0;
          acc_d          = '0;
          err_d          = 1'b0;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        err_d = ~cfg_ok;
        if (!cfg_ok || (len_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if ((cnt_q + LEN_W'(1)) == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave once the pipe will be empty: the final tag is being
        // accumulated this cycle.
        if (tag_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_width_q     <= '0;
      weight_width_q <= '0;
      s_in_q         <= 1'b0;
      s_weight_q     <= 1'b0;
      len_q          <= '0;
      cnt_q          <= '0;
      tag_q          <= '0;
      acc_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_width_q     <= in_width_d;
      weight_width_q <= weight_width_d;
      s_in_q         <= s_in_d;
      s_weight_q     <= s_weight_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      tag_q          <= tag_d;
      acc_q          <= acc_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: doc/fusion_ctrl.md
FUSION_CTRL -- requirements
Module: fusion_ctrl

Interface
REQ-001 Parameter COL_WIDTH, default 13: psum lane base width; result bus is 4*COL_WIDTH bits.
REQ-002 Parameter ROWS, default 4: fusion-unit rows in the column, equal to the beat-to-psum latency in cycles.
REQ-003 Parameter LEN_W, default 10: width of the beat-count field.
REQ-004 The clock is clk and reset is rst; clk is the only clock, and rst is asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accept
- cmd_in_width  in  4  activation width, one-hot {8,4,2,1}
- cmd_weight_width  in  4  weight width, one-hot {8,4,2,1}
- cmd_s_in  in  1  activation signed
- cmd_s_weight  in  1  weight signed
- cmd_len  in  LEN_W  beats in the job
- src_valid  in  1  operand beat available
- src_ready  out  1  operand beat consumed
- fu_en  out  1  beat valid into row 0
- fu_in_width  out  4  held config to array
- fu_weight_width  out  4  held config to array
- fu_s_in  out  1  held config to array
- fu_s_weight  out  1  held config to array
- psum_out  in  4*COL_WIDTH  last-row psum_fwd
- res_valid  out  1  result available
- res_ready  in  1  result accept
- res_data  out  4*COL_WIDTH  accumulated result
- res_err  out  1  job rejected (bad width)

Function
REQ-006 States are IDLE, LOAD, ISSUE, DRAIN, DONE; cmd_ready=1 only in IDLE, src_ready=1 only in ISSUE, and res_valid=1 only in DONE.
REQ-007 IDLE: on cmd_valid, all cmd_* fields SHALL be latched into the fu_* outputs and the length register, the accumulator SHALL be cleared, and the FSM SHALL go to LOAD.
REQ-008 fu_* outputs SHALL change only on a command accept or reset, and SHALL be held stable through DONE.
REQ-009 LOAD (exactly one cycle): if either latched width is not one-hot, or if the length is 0, the FSM SHALL go to DONE; otherwise it SHALL go to ISSUE.
REQ-010 res_err SHALL be 1 in DONE only for a non-one-hot width; a length-0 job SHALL complete with res_err=0 and res_data=0.
REQ-011 ISSUE: fu_en SHALL equal src_valid, and a beat is src_valid&src_ready; when src_valid=0, no beat is counted and fu_en=0 (bubble).
REQ-012 The beat that brings the issued count to the latched length SHALL be the last beat, and the FSM SHALL go to DRAIN on the next cycle.
REQ-013 A ROWS-deep tag shift register SHALL shift every cycle, entering fu_en; when the tag exits, psum_out SHALL be added into the accumulator that same cycle.
REQ-014 DRAIN SHALL exit to DONE on the cycle after the final tag is accumulated; the tag pipe is then empty.
REQ-015 Accumulation SHALL be lane-wise and selected by the latched weight_width; each lane wraps modulo its width, with no carry between lanes:
- 8b: one lane, [4C-1:0]
- 4b: two lanes, [2C-1:0] and [4C-1:2C]
- 2b/1b: four lanes, each C bits
REQ-016 DONE: res_data SHALL hold the accumulator, and res_valid and res_data SHALL be held stable until res_ready=1, at which point the FSM SHALL go to IDLE.
REQ-017 A cmd_valid seen while the FSM is in DONE SHALL NOT be accepted until the cycle after the FSM reaches IDLE.
REQ-018 Latency, with cmd accepted at cycle 0 and src_valid held high: beats occur in cycles 2..len+1, and res_valid rises at cycle len+ROWS+2.

Reset
REQ-019 rst=1 SHALL immediately force:
- the FSM to IDLE
- the accumulator, length and beat counters, and tag pipe to 0
- all outputs to 0, except cmd_ready=1
REQ-020 A reset applied in any state, including mid-ISSUE or mid-DRAIN, SHALL discard the job with no res_valid pulse, and the next command SHALL start from a clean state.

Verification
REQ-021 Basic job: 8b/8b signed, len=3, ROWS=4, psum_out = -5 on each tagged cycle -> res_valid at cycle 9, res_data = -15 (52-bit two's complement), res_err=0.
REQ-022 Lane wrap: 2b weights, len=2, lane0 psum = 8191 then 1, lanes 1-3 = 0 -> lane0 = 0, lane1 = 0 (no carry).
REQ-023 Stall: len=4, src_valid low for 3 cycles after the 2nd beat -> exactly 4 fu_en pulses, and res_valid delayed by 3 cycles relative to REQ-018.
REQ-024 Boundaries:
- weight_width = 4'b0110 -> DONE at cycle 2 with res_err=1, res_data=0, no fu_en pulse
- len=0 -> DONE with res_err=0, res_data=0
REQ-025 Backpressure and reset:
- res_ready low for 5 cycles -> res_data stable and cmd_ready=0 throughout
- rst pulsed mid-DRAIN -> IDLE, no res_valid, and the following job's result is correct
